// File: rtl/vga_timing_param_if.sv
// +--------------------------------------------------------------------+
// | vga_timing_param_if: pixel-enable in, timing/sync/strobe bundle out  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

interface vga_timing_param_if #(
   parameter int CNT_W   = 11,
   parameter int FRAME_W = 8
);
   logic               en;
   logic [CNT_W-1:0]   hcount;
   logic [CNT_W-1:0]   vcount;
   logic               hsync;
   logic               vsync;
   logic               hblnk;
   logic               vblnk;
   logic               de;
   logic               line_start;
   logic               frame_start;
   logic [FRAME_W-1:0] frame_cnt;

   modport master (
      input  en,
      output hcount, vcount, hsync, vsync, hblnk, vblnk, de,
             line_start, frame_start, frame_cnt
   );

   modport slave (
      output en,
      input  hcount, vcount, hsync, vsync, hblnk, vblnk, de,
             line_start, frame_start, frame_cnt
   );
endinterface

`default_nettype wire

// File: rtl/vga_timing_param.sv
// +--------------------------------------------------------------------+
// | vga_timing_param: parameterised VGA timing generator with pixel en  |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module vga_timing_param #(
   parameter int   H_ACTIVE = 800,
   parameter int   H_FP     = 40,
   parameter int   H_SYNC   = 128,
   parameter int   H_BP     = 88,
   parameter int   V_ACTIVE = 600,
   parameter int   V_FP     = 1,
   parameter int   V_SYNC   = 4,
   parameter int   V_BP     = 23,
   parameter logic HS_POL   = 1'b1,
   parameter logic VS_POL   = 1'b1,
   parameter int   CNT_W    = 11,
   parameter int   FRAME_W  = 8
) (
   input  wire logic            clk,
   input  wire logic            rst,
   vga_timing_param_if.master   vif
);

   localparam int c_H_TOT   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int c_V_TOT   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int c_MAX_TOT = (c_H_TOT > c_V_TOT) ? c_H_TOT : c_V_TOT;

   localparam logic [CNT_W-1:0] c_H_LAST   = CNT_W'(c_H_TOT - 1);
   localparam logic [CNT_W-1:0] c_V_LAST   = CNT_W'(c_V_TOT - 1);
   localparam logic [CNT_W-1:0] c_H_ACT    = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] c_V_ACT    = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] c_HS_BEG   = CNT_W'(H_ACTIVE + H_FP);
   localparam logic [CNT_W-1:0] c_HS_END   = CNT_W'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [CNT_W-1:0] c_VS_BEG   = CNT_W'(V_ACTIVE + V_FP);
   localparam logic [CNT_W-1:0] c_VS_END   = CNT_W'(V_ACTIVE + V_FP + V_SYNC);

   if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
       V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_field
      $error("vga_timing_param: every timing field must be at least 1");
   end

   if (CNT_W < 1 || (CNT_W < 31 && (1 << CNT_W) < c_MAX_TOT)) begin : g_bad_cnt_w
      $error("vga_timing_param: CNT_W too narrow for H_TOT/V_TOT");
   end

   logic [CNT_W-1:0]   hcount_q, hcount_d;
   logic [CNT_W-1:0]   vcount_q, vcount_d;
   logic [FRAME_W-1:0] frame_cnt_q, frame_cnt_d;
   logic               hsync_q, hsync_d;
   logic               vsync_q, vsync_d;
   logic               hblnk_q, hblnk_d;
   logic               vblnk_q, vblnk_d;
   logic               de_q, de_d;
   logic               line_start_q, line_start_d;
   logic               frame_start_q, frame_start_d;

   // Decode runs on the next-state counters so every registered output
   // lines up with the counter value it is registered alongside.
   always_comb begin
      hcount_d      = hcount_q;
      vcount_d      = vcount_q;
      frame_cnt_d   = frame_cnt_q;
      line_start_d  = 1'b0;
      frame_start_d = 1'b0;

      if (vif.en) begin
         if (hcount_q == c_H_LAST) begin
            hcount_d     = '0;
            line_start_d = 1'b1;
            if (vcount_q == c_V_LAST) begin
               vcount_d      = '0;
               frame_start_d = 1'b1;
               frame_cnt_d   = frame_cnt_q + FRAME_W'(1);
            end else begin
               vcount_d = vcount_q + CNT_W'(1);
            end
         end else begin
            hcount_d = hcount_q + CNT_W'(1);
         end
      end

      hblnk_d = (hcount_d >= c_H_ACT);
      vblnk_d = (vcount_d >= c_V_ACT);
      de_d    = !hblnk_d && !vblnk_d;
      hsync_d = ((hcount_d >= c_HS_BEG) && (hcount_d < c_HS_END)) ? HS_POL : ~HS_POL;
      vsync_d = ((vcount_d >= c_VS_BEG) && (vcount_d < c_VS_END)) ? VS_POL : ~VS_POL;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hcount_q      <= '0;
         vcount_q      <= '0;
         frame_cnt_q   <= '0;
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         hblnk_q       <= 1'b0;
         vblnk_q       <= 1'b0;
         de_q          <= 1'b1;
         line_start_q  <= 1'b0;
         frame_start_q <= 1'b0;
      end else begin
         hcount_q      <= hcount_d;
         vcount_q      <= vcount_d;
         frame_cnt_q   <= frame_cnt_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
         hblnk_q       <= hblnk_d;
         vblnk_q       <= vblnk_d;
         de_q          <= de_d;
         line_start_q  <= line_start_d;
         frame_start_q <= frame_start_d;
      end
   end

   assign vif.hcount      = hcount_q;
   assign vif.vcount      = vcount_q;
   assign vif.frame_cnt   = frame_cnt_q;
   assign vif.hsync       = hsync_q;
   assign vif.vsync       = vsync_q;
   assign vif.hblnk       = hblnk_q;
   assign vif.vblnk       = vblnk_q;
   assign vif.de          = de_q;
   assign vif.line_start  = line_start_q;
   assign vif.frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_timing_param.sv
// +--------------------------------------------------------------------+
// | tb_vga_timing_param: directed self-checking bench, three configs   |
// | Rev 1.0                                                              |
// +--------------------------------------------------------------------+
`default_nettype none

module tb_vga_timing_param;

   logic clk;
   logic rst0, rst_a, rst_b;
   int   vectors;
   int   miscompares;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Full default mode.
   vga_timing_param_if #(.CNT_W(11), .FRAME_W(8)) if0 ();
   vga_timing_param u_dut0 (.clk(clk), .rst(rst0), .vif(if0));

   // Default horizontal timing, short vertical (V_TOT = 13) for whole frames.
   vga_timing_param_if #(.CNT_W(11), .FRAME_W(8)) if_a ();
   vga_timing_param #(
      .V_ACTIVE(6), .V_FP(1), .V_SYNC(4), .V_BP(2)
   ) u_duta (.clk(clk), .rst(rst_a), .vif(if_a));

   // Tiny mode: H_TOT = 8, V_TOT = 6, active-low hsync.
   vga_timing_param_if #(.CNT_W(4), .FRAME_W(8)) if_b ();
   vga_timing_param #(
      .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
      .HS_POL(1'b0), .CNT_W(4)
   ) u_dutb (.clk(clk), .rst(rst_b), .vif(if_b));

   function automatic logic [63:0] pk(input logic [15:0] h, input logic [15:0] v,
                                      input logic hs, input logic vs, input logic hb,
                                      input logic vb, input logic de, input logic ls,
                                      input logic fs, input logic [7:0] fc);
      return {16'h0, h, v, hs, vs, hb, vb, de, ls, fs, fc, 1'b0};
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run(input int n);
      repeat (n) @(negedge clk);
   endtask

   function automatic logic [63:0] obs0();
      return pk(16'(if0.hcount), 16'(if0.vcount), if0.hsync, if0.vsync, if0.hblnk,
                if0.vblnk, if0.de, if0.line_start, if0.frame_start, if0.frame_cnt);
   endfunction

   function automatic logic [63:0] obs_a();
      return pk(16'(if_a.hcount), 16'(if_a.vcount), if_a.hsync, if_a.vsync, if_a.hblnk,
                if_a.vblnk, if_a.de, if_a.line_start, if_a.frame_start, if_a.frame_cnt);
   endfunction

   function automatic logic [63:0] obs_b();
      return pk(16'(if_b.hcount), 16'(if_b.vcount), if_b.hsync, if_b.vsync, if_b.hblnk,
                if_b.vblnk, if_b.de, if_b.line_start, if_b.frame_start, if_b.frame_cnt);
   endfunction

   initial begin
      int  h, v, fc;
      logic hs, vs, hb, vb;
      vectors     = 0;
      miscompares = 0;
      rst0  = 1'b1;
      rst_a = 1'b1;
      rst_b = 1'b1;
      if0.en  = 1'b1;
      if_a.en = 1'b1;
      if_b.en = 1'b1;

      // Reset state held across two clocks even with en=1.
      run(1);
      check("d0_reset_1", obs0(), pk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      run(1);
      check("d0_reset_2", obs0(), pk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));

      rst0 = 1'b0;
      run(1);
      check("d0_h_first", obs0(), pk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      run(1);
      check("d0_h_second", 64'(if0.hcount), 64'd2);

      // Active/blank edge and horizontal sync window.
      run(797);
      check("d0_h799", obs0(), pk(799, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      run(1);
      check("d0_h800", obs0(), pk(800, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      run(39);
      check("d0_h839", obs0(), pk(839, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      run(1);
      check("d0_h840", obs0(), pk(840, 0, 1, 0, 1, 0, 0, 0, 0, 0));
      run(127);
      check("d0_h967", obs0(), pk(967, 0, 1, 0, 1, 0, 0, 0, 0, 0));
      run(1);
      check("d0_h968", obs0(), pk(968, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      run(86);
      check("d0_h1054", obs0(), pk(1054, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      run(1);
      check("d0_h1055", obs0(), pk(1055, 0, 0, 0, 1, 0, 0, 0, 0, 0));
      run(1);
      check("d0_wrap", obs0(), pk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0));
      run(1);
      check("d0_after_wrap", obs0(), pk(1, 1, 0, 0, 0, 0, 1, 0, 0, 0));

      // Alternating enable: advance only on enabled edges.
      for (int i = 0; i < 10; i++) begin
         if0.en = 1'b0;
         run(1);
         check("d0_toggle_hold", 64'(if0.hcount), 64'(1 + i));
         if0.en = 1'b1;
         run(1);
         check("d0_toggle_step", 64'(if0.hcount), 64'(2 + i));
      end
      check("d0_toggle_v", 64'(if0.vcount), 64'd1);

      run(1044);
      check("d0_h1055_b", obs0(), pk(1055, 1, 0, 0, 1, 0, 0, 0, 0, 0));
      run(1);
      check("d0_wrap_b", obs0(), pk(0, 2, 0, 0, 0, 0, 1, 1, 0, 0));

      // Freeze right after a wrap: strobe must drop, everything else holds.
      if0.en = 1'b0;
      run(1);
      check("d0_freeze_1", obs0(), pk(0, 2, 0, 0, 0, 0, 1, 0, 0, 0));
      run(9);
      check("d0_freeze_10", obs0(), pk(0, 2, 0, 0, 0, 0, 1, 0, 0, 0));
      if0.en = 1'b1;
      run(1);
      check("d0_resume", obs0(), pk(1, 2, 0, 0, 0, 0, 1, 0, 0, 0));

      // Short-vertical config: every cycle over two whole frames.
      rst_a = 1'b0;
      for (int n = 1; n <= 27458; n++) begin
         run(1);
         h  = n % 1056;
         v  = (n / 1056) % 13;
         fc = (n / 13728) % 256;
         hs = (h >= 840) && (h < 968);
         vs = (v >= 7) && (v < 11);
         hb = (h >= 800);
         vb = (v >= 6);
         check("a_cycle", obs_a(),
               pk(16'(h), 16'(v), hs, vs, hb, vb, !hb && !vb, h == 0,
                  (h == 0) && (v == 0), 8'(fc)));
      end

      // Mid-frame reset inside both sync windows.
      run(9346);
      check("a_pre_reset", obs_a(), pk(900, 8, 1, 1, 1, 1, 0, 0, 0, 2));
      rst_a = 1'b1;
      #1;
      check("a_async_reset", obs_a(), pk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      run(2);
      check("a_reset_held", obs_a(), pk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      rst_a = 1'b0;
      run(1);
      check("a_restart", obs_a(), pk(1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
      run(1055);
      check("a_first_wrap", obs_a(), pk(0, 1, 0, 0, 0, 0, 1, 1, 0, 0));

      // Tiny config with active-low hsync.
      check("b_reset", obs_b(), pk(0, 0, 1, 0, 0, 0, 1, 0, 0, 0));
      rst_b = 1'b0;
      for (int n = 1; n <= 100; n++) begin
         run(1);
         h  = n % 8;
         v  = (n / 8) % 6;
         fc = n / 48;
         hs = !((h == 5) || (h == 6));
         vs = (v == 4);
         hb = (h >= 4);
         vb = (v >= 3);
         check("b_cycle", obs_b(),
               pk(16'(h), 16'(v), hs, vs, hb, vb, !hb && !vb, h == 0,
                  (n % 48) == 0, 8'(fc)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/vga_timing_param.md
Name: vga_timing_param

Overview:
- Next-generation VGA timing generator: all horizontal/vertical timing fields are parameters, sync polarity is selectable, and a pixel-clock enable is added.
- Produces the usual hcount/vcount/sync/blank outputs, plus data-enable, line/frame start strobes and a frame counter.
- Sits at the head of the video pipeline and drives the draw/overlay stages.
- Defaults reproduce the current 800x600 @ 40 MHz mode: 1056 total columns, 628 total lines.

Parameters:
H_ACTIVE, 800, visible pixels per line
H_FP, 40, horizontal front porch (pixels)
H_SYNC, 128, horizontal sync width (pixels)
H_BP, 88, horizontal back porch (pixels)
V_ACTIVE, 600, visible lines per frame
V_FP, 1, vertical front porch (lines)
V_SYNC, 4, vertical sync width (lines)
V_BP, 23, vertical back porch (lines)
HS_POL, 1, hsync active level (1 = active-high)
VS_POL, 1, vsync active level
CNT_W, 11, width of hcount/vcount
FRAME_W, 8, width of frame_cnt

Ports:
clk  input  1  pixel-domain clock
rst  input  1  reset, asynchronous, active-high
en  input  1  pixel advance enable; counters step only when 1
hcount  output  CNT_W  current column, 0..H_TOT-1
vcount  output  CNT_W  current line, 0..V_TOT-1
hsync  output  1  horizontal sync, level set by HS_POL
vsync  output  1  vertical sync, level set by VS_POL
hblnk  output  1  horizontal blanking
vblnk  output  1  vertical blanking
de  output  1  display enable = !hblnk && !vblnk
line_start  output  1  one-clk strobe when hcount wraps to 0
frame_start  output  1  one-clk strobe when hcount and vcount both wrap to 0
frame_cnt  output  FRAME_W  completed-frame counter

Behaviour:
- Derived constants: H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOT likewise. Elaboration error if any field is < 1, or if 2**CNT_W < max(H_TOT, V_TOT).
- Reset (async assert, sync release): hcount=0, vcount=0, hblnk=0, vblnk=0, de=1, hsync=~HS_POL, vsync=~VS_POL, line_start=0, frame_start=0, frame_cnt=0.
- No strobe is generated by reset itself.
- All outputs are registered and mutually aligned: on any clock edge, every decoded output corresponds to the hcount/vcount value presented in that same cycle. The decode uses next-state counter values, so there is zero latency between counter and decode.
- Rising edge with en=1:
  - hcount = (hcount == H_TOT-1) ? 0 : hcount+1.
  - On hcount wrap: vcount = (vcount == V_TOT-1) ? 0 : vcount+1.
  - On simultaneous h and v wrap: frame_cnt += 1, modulo 2**FRAME_W.
- Rising edge with en=0: counters, frame_cnt and all decoded levels hold; line_start and frame_start are forced to 0.
- Decode, with hcount/vcount being the values shown that cycle:
  - hblnk = hcount >= H_ACTIVE.
  - vblnk = vcount >= V_ACTIVE.
  - hsync active iff H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (defaults: 840..967).
  - vsync active iff V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (defaults: 601..604).
  - Active level = POL; inactive = ~POL.
- Strobes:
  - line_start = 1 for exactly one clk, the cycle in which hcount first shows 0 after an enabled wrap.
  - frame_start = 1 for exactly one clk, the same cycle, only when vcount also wrapped to 0.
  - frame_start implies line_start.
- Reset asserted mid-frame: all outputs return to reset values immediately. Counting restarts at (0,0) on the first enabled edge after release; the next strobe appears only on the following wrap.
- Widths: counter compares are unsigned at CNT_W; no overflow is possible given the elaboration check.

Test Plan:
1. Defaults, rst pulsed for 2 clk, en=1 -> during reset hcount=vcount=0, hsync=vsync=0, de=1, strobes 0; after release hcount steps 0,1,2,...
2. Defaults, run to line end -> hcount 1054, 1055, 0; vcount increments on the 0 cycle; line_start=1 for that one clk only; hblnk=1 for hcount 800..1055, 0 at 0.
3. Defaults, sync windows -> hsync 0 at 839, 1 at 840..967, 0 at 968; vsync 0 at 600, 1 at 601..604, 0 at 605; vblnk 1 for 600..627.
4. Defaults, two full frames -> frame_start pulses exactly once per 1056*628 clk; frame_cnt 0 -> 1 -> 2; frame_start coincides with line_start.
5. en toggled 1,0,1,0... -> counters advance every other clk; no strobe is ever high for two consecutive clocks; with en=0 held for 10 clk, all outputs are frozen.
6. H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=3, V_FP=V_SYNC=V_BP=1, HS_POL=0, CNT_W=4 -> H_TOT=8, V_TOT=6; hsync low only at hcount 5..6; de high for hcount<4 and vcount<3; frame_start every 48 clk.
7. Reset asserted at hcount=500, vcount=300 -> outputs return to reset values the same cycle; after release the sequence restarts at 0 with frame_cnt=0.
